alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one ALU instance among N_REQ independent requesters using a round-robin arbiter.
- Each requester presents operands and an opcode through a valid/ready handshake. The winner's operation is registered onto the ALU input ports.
- The result is returned on a broadcast response bus, tagged with the requester index.
- Sits between the requesting datapath blocks and the ALU `a`/`b`/`op`/`c`/`out` ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width; matches ALU `a`/`b`/`out`.
- OP_W, 3, opcode width; matches ALU `op`.
- ALU_LAT, 1, ALU latency in cycles from registered inputs to valid `out`/`c` (1..4).
- ID_W, $clog2(N_REQ), requester tag width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  when 1, no new grant is issued; in-flight operations complete.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  packed operand B, same packing.
- req_op  in  N_REQ*OP_W  packed opcodes.
- req_ready  out  N_REQ  one-hot-or-zero grant; handshake when req_valid[i] & req_ready[i].
- alu_a  out  WIDTH  to ALU `a`.
- alu_b  out  WIDTH  to ALU `b`.
- alu_op  out  OP_W  to ALU `op`.
- alu_out  in  WIDTH  from ALU `out`.
- alu_c  in  1  from ALU `c` (carry/flag).
- rsp_valid  out  1  response valid, one cycle pulse per operation.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- rsp_out  out  WIDTH  captured alu_out.
- rsp_c  out  1  captured alu_c.
- busy  out  1  1 while any operation is in flight.
- issue_cnt  out  16  total handshakes since reset; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async assert, sync deassert by design): every output is driven to 0.
  - Covers alu_a, alu_b, alu_op, rsp_*, busy and issue_cnt.
  - Pointer last_grant = N_REQ-1, so requester 0 has top priority after reset.
  - Tag pipeline is cleared; in-flight operations are discarded with no rsp_valid.
- Arbitration (combinational, per cycle):
  - If hold=0, search from (last_grant+1) mod N_REQ upward with wrap; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - Otherwise req_ready=0.
  - req_ready never depends on the same requester's data; at most one bit is set.
- Handshake at edge T:
  - alu_a/alu_b/alu_op take the granted requester's fields at T+1.
  - last_grant takes the granted index and issue_cnt increments.
  - With no handshake, alu_a/alu_b/alu_op hold their last value; last_grant is unchanged.
- Tag pipeline: ALU_LAT+1 stages of {valid, id}. Stage 0 loads at the handshake edge; each stage shifts every cycle.
- Response: at edge T+1+ALU_LAT, rsp_valid=1 and rsp_id = the issuing id. rsp_out/rsp_c capture alu_out/alu_c in that cycle.
  - There is no response backpressure; requesters must accept the broadcast.
  - rsp_out/rsp_c hold their value when rsp_valid=0.
- Throughput: one issue per cycle; back-to-back responses are allowed. Ordering is strictly issue order.
- busy = OR of all tag-stage valids.
- hold asserted mid-stream: it blocks new grants from the same cycle, does not cancel in-flight operations, and leaves last_grant untouched.
- A requester may deassert req_valid without a handshake; no state changes.
- A single continuous requester is granted every cycle. Fairness: with all N_REQ valid, each is granted exactly once per N_REQ consecutive grants.

Test Plan:
- Reset, then req_valid=4'b0001, a=8'h05, b=8'h03, op=3'd0 (ADD) → req_ready[0] the same cycle; rsp_valid at handshake+2 (ALU_LAT=1) with rsp_id=0, rsp_out=8'h08, rsp_c=0; issue_cnt=1.
- req_valid=4'b1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 responses in the same order; busy high from first handshake+1 until last response.
- Requesters 1 and 3 valid, last_grant=2 → requester 3 granted first, then 1; with a=8'hFF, b=8'h01, ADD from requester 3 → rsp_out=8'h00, rsp_c=1.
- hold=1 with req_valid=4'b0110 → req_ready=0 every cycle and the earlier in-flight response still delivered. Release hold → requester 1 granted next (last_grant was 0).
- Assert rst_n=0 one cycle after a handshake → no rsp_valid ever produced, all outputs 0 immediately, and the first grant after release goes to requester 0.
- Force issue_cnt to 16'hFFFF via 65535 handshakes → next handshake gives issue_cnt=16'h0000.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares a single ALU among N_REQ requesters. A round-robin arbiter picks at
//   most one valid requester per cycle. The winner's operands are registered
//   onto the ALU inputs. A {valid,id} tag pipeline tracks each operation
//   through the ALU latency. The result is then broadcast, tagged with the
//   issuing requester's index.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   hold              blocks new grants; in-flight operations still complete
//   req_valid         per-requester request valid
//   req_a, req_b      packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op            packed opcodes, requester i at [i*OP_W +: OP_W]
//   req_ready         one-hot-or-zero grant (combinational)
//   alu_a/b/op        registered operands/opcode to the ALU
//   alu_out, alu_c    ALU result and flag, valid ALU_LAT cycles after alu_a/b/op
//   rsp_valid         one-cycle pulse per completed operation
//   rsp_id            requester index of the completed operation
//   rsp_out, rsp_c    captured ALU result/flag; held while rsp_valid=0
//   busy              any operation in flight in the tag pipeline
//   issue_cnt         handshakes since reset, wrapping at 16 bits
module alu_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]  req_op,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_c,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_out,
  output logic                   rsp_c,
  output logic                   busy,
  output logic [15:0]            issue_cnt
);

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic             hs;

  logic [WIDTH-1:0] sel_a, sel_b;
  logic [OP_W-1:0]  sel_op;

  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [ALU_LAT:0] tv_q, tv_d;
  logic [ID_W-1:0]  tid_q [ALU_LAT+1];
  logic [ID_W-1:0]  tid_d [ALU_LAT+1];
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_c_q, rsp_c_d;
  logic [15:0]      issue_cnt_q, issue_cnt_d;

  // Round-robin search starting one past the last winner, wrapping modulo N_REQ.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    if (!hold) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = ID_W'((32'(last_grant_q) + k + 1) % N_REQ);
        if (!found && req_valid[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = idx;
        end
      end
    end
  end

  assign hs = |gnt;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    alu_a_d      = hs ? sel_a  : alu_a_q;
    alu_b_d      = hs ? sel_b  : alu_b_q;
    alu_op_d     = hs ? sel_op : alu_op_q;
    last_grant_d = hs ? gnt_id : last_grant_q;
    issue_cnt_d  = issue_cnt_q + {15'b0, hs};

    // Tag stage k describes the operation whose operands reached the ALU k cycles ago;
    // the last stage marks the cycle in which alu_out/alu_c belong to it.
    tv_d     = {tv_q[ALU_LAT-1:0], hs};
    tid_d[0] = gnt_id;
    for (int unsigned k = 1; k <= ALU_LAT; k++) begin
      tid_d[k] = tid_q[k-1];
    end

    rsp_valid_d = tv_q[ALU_LAT];
    rsp_id_d    = tv_q[ALU_LAT] ? tid_q[ALU_LAT] : rsp_id_q;
    rsp_out_d   = tv_q[ALU_LAT] ? alu_out        : rsp_out_q;
    rsp_c_d     = tv_q[ALU_LAT] ? alu_c          : rsp_c_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tv_q         <= '0;
      for (int unsigned k = 0; k <= ALU_LAT; k++) begin
        tid_q[k] <= '0;
      end
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_out_q    <= '0;
      rsp_c_q      <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tv_q         <= tv_d;
      tid_q        <= tid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_c_q      <= rsp_c_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  assign req_ready = gnt;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_c     = rsp_c_q;
  assign busy      = |tv_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: directed vectors with hand-computed results.
// Expected responses go into a scoreboard queue as they are issued. A monitor
// pops and compares the queue on every rsp_valid.
module tb_alu_rr_scheduler;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int OW  = 3;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N*OW-1:0] req_op = '0;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    alu_a, alu_b;
  logic [OW-1:0]   alu_op;
  logic [W-1:0]    alu_out = '0;
  logic            alu_c = 1'b0;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_out;
  logic            rsp_c;
  logic            busy;
  logic [15:0]     issue_cnt;

  alu_rr_scheduler #(.N_REQ(N), .WIDTH(W), .OP_W(OW), .ALU_LAT(LAT), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_c(rsp_c),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // One-cycle ALU: 0 ADD (c=carry), 1 SUB (c=borrow), 2 AND, 3 OR, 4 XOR, else pass a.
  always @(posedge clk) begin
    case (alu_op)
      3'd0: {alu_c, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: begin alu_out <= alu_a - alu_b; alu_c <= (alu_a < alu_b); end
      3'd2: begin alu_out <= alu_a & alu_b; alu_c <= 1'b0; end
      3'd3: begin alu_out <= alu_a | alu_b; alu_c <= 1'b0; end
      3'd4: begin alu_out <= alu_a ^ alu_b; alu_c <= 1'b0; end
      default: begin alu_out <= alu_a; alu_c <= 1'b0; end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] id;
    logic [7:0] out;
    logic       c;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation,
  // including the cycle in which it arrives.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got id=%0d out=%0h c=%0b, expected no response (t=%0t)",
                 rsp_id, rsp_out, rsp_c, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp{id,out,c,cyc}", {rsp_id, rsp_out, rsp_c, 32'(cyc)}, {e.id, e.out, e.c, 32'(e.cyc)});
      end
    end
  end

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_op[i*OW +: OW] = op;
  endtask

  // Drive one cycle's inputs on the falling edge, check the grant, and record
  // the response expected from that grant.
  task automatic step(input logic [N-1:0] v, input logic h, input logic [N-1:0] exp_rdy,
                      input logic push, input logic [1:0] id, input logic [7:0] eo, input logic ec);
    @(negedge clk);
    req_valid = v;
    hold      = h;
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (push) sb.push_back('{id, eo, ec, cyc + LAT + 2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    hold      = 1'b0;
    #1;
    chk("reset_outputs_zero",
        64'({alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_out, rsp_c, busy, issue_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and a single ADD from requester 0.
    do_reset();
    set_req(0, 8'h05, 8'h03, 3'd0);
    step(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 1'b0);
    idle(4);
    chk("issue_cnt_after_one", 64'(issue_cnt), 64'd1);

    // All four valid: strict round robin from requester 0.
    do_reset();
    set_req(0, 8'h01, 8'h02, 3'd0);   // 03, c=0
    set_req(1, 8'h0F, 8'h01, 3'd1);   // 0E, c=0
    set_req(2, 8'hF0, 8'h3C, 3'd2);   // 30, c=0
    set_req(3, 8'h81, 8'h80, 3'd0);   // 01, c=1
    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0: step(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h03, 1'b0);
        1: step(4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h0E, 1'b0);
        2: step(4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h30, 1'b0);
        default: step(4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h01, 1'b1);
      endcase
      if (k == 0) chk("busy_before_first_issue", 64'(busy), 64'd0);
      if (k == 1) chk("busy_after_first_issue", 64'(busy), 64'd1);
    end
    idle(1);
    chk("busy_tail_1", 64'(busy), 64'd1);
    idle(1);
    chk("busy_tail_2", 64'(busy), 64'd1);
    idle(1);
    chk("busy_drained", 64'(busy), 64'd0);
    chk("issue_cnt_after_eight", 64'(issue_cnt), 64'd8);
    idle(2);

    // last_grant = 2, then requesters 1 and 3 compete: 3 first, then 1.
    do_reset();
    set_req(1, 8'h0F, 8'h01, 3'd1);   // 0E, c=0
    set_req(2, 8'hF0, 8'h3C, 3'd2);   // 30, c=0
    set_req(3, 8'hFF, 8'h01, 3'd0);   // 00, c=1
    step(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h30, 1'b0);
    step(4'b1010, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h00, 1'b1);
    step(4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h0E, 1'b0);
    idle(4);

    // hold blocks grants but not the in-flight op; release resumes after last_grant=0.
    do_reset();
    set_req(0, 8'h05, 8'h03, 3'd0);   // 08, c=0
    step(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 1'b0);
    step(4'b0110, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    step(4'b0110, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    step(4'b0110, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("issue_cnt_during_hold", 64'(issue_cnt), 64'd1);
    step(4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h0E, 1'b0);
    step(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h30, 1'b0);
    idle(4);

    // Reset right after a handshake discards the op; next grant goes to requester 0.
    do_reset();
    step(4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0);
    do_reset();
    idle(3);
    step(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 1'b0);
    idle(4);

    // issue_cnt wrap: 65535 handshakes from one continuous requester, then one more.
    do_reset();
    for (int i = 0; i < 65535; i++) step(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("issue_cnt_max", 64'(issue_cnt), 64'hFFFF);
    step(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("issue_cnt_wrap", 64'(issue_cnt), 64'h0000);
    idle(4);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
